// File: rtl/fp_normalize_round_stage.sv
// fp_normalize_round_stage: two-stage leading-one normalize, exponent adjust and IEEE-754 single packing per lane; define FP_DENORMAL_EN for denormal results instead of flush-to-zero
module fp_normalize_round_stage #(
    parameter int LANES = 16,
    parameter int THREAD_IDX_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [THREAD_IDX_WIDTH-1:0] in_thread,
    input  logic [LANES-1:0]            in_mask,
    input  logic [LANES*32-1:0]         in_significand,
    input  logic [LANES*8-1:0]          in_exponent,
    input  logic [LANES-1:0]            in_sign,
    input  logic [LANES-1:0]            in_logical_subtract,
    input  logic [LANES-1:0]            in_is_inf,
    input  logic [LANES-1:0]            in_is_nan,
    input  logic                        flush_en,
    input  logic [THREAD_IDX_WIDTH-1:0] flush_thread,
    output logic                        out_valid,
    output logic [THREAD_IDX_WIDTH-1:0] out_thread,
    output logic [LANES-1:0]            out_mask,
    output logic [LANES*32-1:0]         out_result
);
    logic                        a_valid;
    logic [THREAD_IDX_WIDTH-1:0] a_thread;
    logic [LANES-1:0]            a_mask, a_sign, a_lsub, a_inf, a_nan, a_zero, in_zero;
    logic [LANES-1:0][31:0]      a_sig, result;
    logic [LANES-1:0][7:0]       a_exp;
    logic [LANES-1:0][4:0]       in_pos, a_pos;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [4:0]        pos;
        logic signed [9:0] e;
        logic [22:0]       man;
        logic [31:0]       sub, res;
        // leading-one position of the incoming significand (0 when it is zero)
        always_comb begin
            pos = '0;
            for (int b = 0; b < 32; b++) if (in_significand[l*32+b]) pos = 5'(b);
        end
        // normalize, adjust exponent and select the packed result by priority
        always_comb begin
            e = 10'(a_exp[l]) + 10'(a_pos[l]) - 10'd23;
            man = 23'(a_pos[l] > 5'd23 ? a_sig[l] >> (a_pos[l] - 5'd23) : a_sig[l] << (5'd23 - a_pos[l]));
`ifdef FP_DENORMAL_EN
            sub = {a_sign[l], 8'h00, 23'({1'b1, man} >> (10'd1 - e))};
`else
            sub = {a_sign[l], 31'b0};
`endif
            res = a_nan[l] ? 32'h7FC00000 :
                  a_inf[l] ? {a_sign[l], 8'hFF, 23'b0} :
                  a_zero[l] ? {a_sign[l] & ~a_lsub[l], 31'b0} :
                  e >= 10'sd255 ? {a_sign[l], 8'hFF, 23'b0} :
                  e <= 10'sd0 ? sub : {a_sign[l], e[7:0], man};
        end
        assign in_pos[l]  = pos;
        assign in_zero[l] = ~|in_significand[l*32 +: 32];
        assign result[l]  = res;
    end

    // stage 1: capture the beat, dropping it when its own thread is flushed this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid  <= 1'b0;
            a_thread <= '0;
            a_mask   <= '0;
            a_sig    <= '0;
            a_exp    <= '0;
            a_sign   <= '0;
            a_lsub   <= '0;
            a_inf    <= '0;
            a_nan    <= '0;
            a_zero   <= '0;
            a_pos    <= '0;
        end else begin
            a_valid  <= in_valid && !(flush_en && flush_thread == in_thread);
            a_thread <= in_thread;
            a_mask   <= in_mask;
            a_sig    <= in_significand;
            a_exp    <= in_exponent;
            a_sign   <= in_sign;
            a_lsub   <= in_logical_subtract;
            a_inf    <= in_is_inf;
            a_nan    <= in_is_nan;
            a_zero   <= in_zero;
            a_pos    <= in_pos;
        end
    end

    // stage 2: retire the stage-1 beat unless its thread is being rolled back now
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_thread <= '0;
            out_mask   <= '0;
            out_result <= '0;
        end else begin
            out_valid  <= a_valid && !(flush_en && flush_thread == a_thread);
            out_thread <= a_thread;
            out_mask   <= a_mask;
            out_result <= result;
        end
    end
endmodule

// File: tb/tb_fp_normalize_round_stage.sv
// tb_fp_normalize_round_stage: table vectors, flush/reset sequences and random beats checked against an arithmetic model
module tb_fp_normalize_round_stage;
    localparam int L = 16;
    logic clk = 1'b0, reset;
    logic in_valid, flush_en;
    logic [1:0] in_thread, flush_thread, out_thread;
    logic [L-1:0] in_mask, in_sign, in_logical_subtract, in_is_inf, in_is_nan, out_mask;
    logic [L*32-1:0] in_significand, out_result;
    logic [L*8-1:0] in_exponent;
    logic out_valid;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fp_normalize_round_stage #(.LANES(L), .THREAD_IDX_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_thread(in_thread), .in_mask(in_mask),
        .in_significand(in_significand), .in_exponent(in_exponent), .in_sign(in_sign),
        .in_logical_subtract(in_logical_subtract), .in_is_inf(in_is_inf), .in_is_nan(in_is_nan),
        .flush_en(flush_en), .flush_thread(flush_thread), .out_valid(out_valid),
        .out_thread(out_thread), .out_mask(out_mask), .out_result(out_result)
    );

    typedef struct { logic [31:0] sig; logic [7:0] ex; logic s, ls, inf, nan; logic [31:0] exp_res; } vec_t;
    typedef struct { logic v; logic [1:0] t; logic [L-1:0] m; logic [L*32-1:0] r; } beat_t;
    beat_t prev, cur;
    vec_t tbl[15];

`ifdef FP_DENORMAL_EN
    localparam logic [31:0] DEN = 32'h00400000;
`else
    localparam logic [31:0] DEN = 32'h00000000;
`endif

    // value = sig * 2^(ex-127-23); normalize by finding the power of two
    function automatic logic [31:0] ref_fp(input logic [31:0] sig, input logic [7:0] ex, input logic s, ls, inf, nan);
        int p, e;
        longint m;
        if (nan) return 32'h7FC00000;
        if (inf) return {s, 8'hFF, 23'b0};
        if (sig == 0) return {s & !ls, 31'b0};
        p = 0;
        for (longint v = longint'(sig); v > 1; v = v / 2) p++;
        e = int'(ex) + p - 23;
        m = (longint'(sig) << 23) >> p;
        if (e >= 255) return {s, 8'hFF, 23'b0};
        if (e <= 0) begin
`ifdef FP_DENORMAL_EN
            m = m >> (1 - e);
            return {s, 8'h00, m[22:0]};
`else
            return {s, 31'b0};
`endif
        end
        return {s, e[7:0], m[22:0]};
    endfunction

    task automatic chk(input string n, input logic [L*32-1:0] a, input logic [L*32-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic record();
        cur.v = in_valid;
        cur.t = in_thread;
        cur.m = in_mask;
        for (int i = 0; i < L; i++)
            cur.r[i*32 +: 32] = ref_fp(in_significand[i*32 +: 32], in_exponent[i*8 +: 8], in_sign[i],
                                       in_logical_subtract[i], in_is_inf[i], in_is_nan[i]);
    endtask

    task automatic drive_rand(input logic v, input logic [1:0] t);
        in_valid = v;
        in_thread = t;
        in_mask = 16'($urandom);
        for (int i = 0; i < L; i++) begin
            in_significand[i*32 +: 32] = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom >> $urandom_range(0, 31);
            in_exponent[i*8 +: 8] = 8'($urandom);
            in_sign[i] = 1'($urandom);
            in_logical_subtract[i] = 1'($urandom);
            in_is_inf[i] = $urandom_range(0, 15) == 0;
            in_is_nan[i] = $urandom_range(0, 15) == 0;
        end
        record();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        record();
    endtask

    task automatic tick(input logic fl, input logic [1:0] ft);
        flush_en = fl;
        flush_thread = ft;
        if (fl && cur.v && cur.t == ft) cur.v = 1'b0;
        if (fl && prev.v && prev.t == ft) prev.v = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", L*32'(out_valid), L*32'(prev.v));
        if (prev.v) begin
            chk("out_thread", L*32'(out_thread), L*32'(prev.t));
            chk("out_mask", L*32'(out_mask), L*32'(prev.m));
            chk("out_result", out_result, prev.r);
        end
        prev = cur;
    endtask

    initial begin
        tbl = '{
            '{32'h00800000, 8'h7F, 0, 0, 0, 0, 32'h3F800000},
            '{32'h01000000, 8'h7F, 0, 0, 0, 0, 32'h40000000},
            '{32'h01000000, 8'h7F, 1, 0, 0, 0, 32'hC0000000},
            '{32'h00000001, 8'h7F, 0, 1, 0, 0, 32'h34000000},
            '{32'h00000000, 8'h7F, 1, 1, 0, 0, 32'h00000000},
            '{32'h00000000, 8'h7F, 1, 0, 0, 0, 32'h80000000},
            '{32'h01000000, 8'hFE, 0, 0, 0, 0, 32'h7F800000},
            '{32'h00800000, 8'hFE, 0, 0, 0, 0, 32'h7F000000},
            '{32'h01234567, 8'h10, 1, 0, 0, 1, 32'h7FC00000},
            '{32'h00800000, 8'h10, 1, 0, 1, 0, 32'hFF800000},
            '{32'h00400000, 8'h01, 0, 0, 0, 0, DEN},
            '{32'h00800000, 8'h00, 0, 0, 0, 0, DEN},
            '{32'h00800000, 8'h01, 0, 0, 0, 0, 32'h00800000},
            '{32'h01FFFFFF, 8'h7F, 0, 0, 0, 0, 32'h407FFFFF},
            '{32'h00000000, 8'h00, 0, 0, 1, 1, 32'h7FC00000}
        };
        prev = '{v: 1'b0, t: 2'd0, m: '0, r: '0};
        cur = prev;
        reset = 1'b1;
        flush_en = 1'b0;
        flush_thread = 2'd0;
        drive_rand(1'b0, 2'd0);
        @(posedge clk);
        #1;
        chk("reset_valid", L*32'(out_valid), '0);
        chk("reset_result", out_result, '0);
        chk("reset_mask", L*32'(out_mask), '0);
        reset = 1'b0;
        idle();
        tick(1'b0, 2'd0);
        for (int k = 0; k < 15; k++) begin
            drive_rand(1'b1, 2'd0);
            in_significand[31:0] = tbl[k].sig;
            in_exponent[7:0] = tbl[k].ex;
            in_sign[0] = tbl[k].s;
            in_logical_subtract[0] = tbl[k].ls;
            in_is_inf[0] = tbl[k].inf;
            in_is_nan[0] = tbl[k].nan;
            record();
            tick(1'b0, 2'd0);
            idle();
            tick(1'b0, 2'd0);
            checks++;
            if (!out_valid || out_result[31:0] !== tbl[k].exp_res) begin
                errors++;
                $display("FAIL table[%0d]: got valid=%0b result=%h expected valid=1 result=%h", k, out_valid, out_result[31:0], tbl[k].exp_res);
            end
        end
        drive_rand(1'b1, 2'd2);
        tick(1'b0, 2'd0);
        drive_rand(1'b1, 2'd1);
        tick(1'b1, 2'd2);
        chk("flush_stage1_killed", L*32'(out_valid), '0);
        idle();
        tick(1'b0, 2'd0);
        chk("other_thread_valid", L*32'(out_valid), L*32'(1));
        chk("other_thread_id", L*32'(out_thread), L*32'(1));
        drive_rand(1'b1, 2'd3);
        tick(1'b1, 2'd3);
        idle();
        tick(1'b0, 2'd0);
        chk("same_cycle_flush_dropped", L*32'(out_valid), '0);
        drive_rand(1'b1, 2'd0);
        tick(1'b0, 2'd0);
        drive_rand(1'b1, 2'd1);
        tick(1'b0, 2'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_valid", L*32'(out_valid), '0);
        chk("async_reset_result", out_result, '0);
        idle();
        cur.v = 1'b0;
        prev.v = 1'b0;
        tick(1'b0, 2'd0);
        reset = 1'b0;
        tick(1'b0, 2'd0);
        tick(1'b0, 2'd0);
        for (int c = 0; c < 400; c++) begin
            drive_rand($urandom_range(0, 3) != 0, 2'($urandom));
            tick($urandom_range(0, 4) == 0, 2'($urandom));
        end
        idle();
        tick(1'b0, 2'd0);
        tick(1'b0, 2'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_normalize_round_stage.md
Name: fp_normalize_round_stage

Overview:
- Receiving end of the FP add-pipeline interface: consumes per-lane unnormalized significand sums, exponents, signs and special-value flags, and produces packed IEEE-754 single-precision results.
- Performs leading-one detection, normalizing shift, exponent adjustment, overflow/underflow handling and final packing.
- Two-stage internal pipeline, fixed latency 2; per-thread flush kills in-flight work on rollback.
- Sits between the significand-add stage and writeback.

Parameters:
LANES, 16, number of vector lanes processed in parallel
THREAD_IDX_WIDTH, 2, width of thread index

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_thread  input  THREAD_IDX_WIDTH  thread of input beat
in_mask  input  LANES  lane enable mask, passed through
in_significand  input  LANES*32  unsigned unnormalized significand per lane; hidden-bit position 23
in_exponent  input  LANES*8  biased exponent per lane, relative to bit 23
in_sign  input  LANES  result sign per lane
in_logical_subtract  input  LANES  lane performed magnitude subtraction
in_is_inf  input  LANES  force infinity
in_is_nan  input  LANES  force NaN
flush_en  input  1  rollback request
flush_thread  input  THREAD_IDX_WIDTH  thread being rolled back
out_valid  output  1  result valid
out_thread  output  THREAD_IDX_WIDTH  thread of result
out_mask  output  LANES  lane mask of result
out_result  output  LANES*32  packed IEEE-754 result per lane

Behaviour:
- Reset: all outputs and stage-1 registers go to 0 asynchronously. Mid-operation reset discards in-flight beats, with no output on release.
- Latency: a beat captured at edge N appears on outputs after edge N+2. One beat per cycle. No backpressure.

Stage 1 (register A):
- Captures the inputs plus a per-lane 5-bit leading-one position p (0..31) and a zero flag (significand == 0).
- A_valid <= in_valid && !(flush_en && flush_thread == in_thread).
- If A_valid is set and flush_en && flush_thread == A_thread, A_valid clears at the next edge instead of advancing to stage 2.

Stage 2 (output register), per lane:
- Exponent math uses a 10-bit signed intermediate: e = in_exponent + p - 23.
- If p > 23: significand >> (p - 23), truncating. Rounding was already applied upstream; only carry-out case p = 24 occurs legitimately.
- If p < 23: significand << (23 - p).
- Priority, first match wins:
  1. NaN -> 0x7FC00000.
  2. inf -> {sign, 0xFF, 23'b0}.
  3. zero -> +0 (0x00000000) if logical_subtract, else {sign, 31'b0}.
  4. e >= 255 -> {sign, 0xFF, 0}.
  5. e <= 0 -> flush to {sign, 31'b0}.
  6. Otherwise -> {sign, e[7:0], shifted[22:0]}.
- Output register is not affected by flush; beats already in it retire.
- out_valid, out_thread and out_mask update every cycle from stage 1. Result data is don't-care when out_valid = 0.
- Simultaneous input and flush of the same thread: input dropped and the stage-1 entry killed. Other threads are unaffected.

Optional Feature:
FP_DENORMAL_EN
- Defined: when e <= 0 (and not case 1-4), produce a denormal. Significand is the normalized value >> (1 - e), truncating, with exponent field 0. Shift >= 24 yields signed zero.
- Undefined: flush-to-zero as in case 5.

Test Plan:
1. sig=0x00800000, exp=0x7F, sign=0, valid at N -> out_valid at N+2, result 0x3F800000.
2. sig=0x01000000, exp=0x7F -> 0x40000000. Same input with sign=1 -> 0xC0000000.
3. sig=0x00000001, exp=0x7F, logical_subtract=1 -> 0x34000000. sig=0, logical_subtract=1, sign=1 -> 0x00000000.
4. sig=0x01000000, exp=0xFE -> 0x7F800000. is_nan=1 -> 0x7FC00000. is_inf=1, sign=1 -> 0xFF800000.
5. Underflow:
   - sig=0x00400000, exp=0x01 -> 0x00000000 without FP_DENORMAL_EN, 0x00400000 with it.
   - sig=0x00800000, exp=0x00 -> 0x00000000 without, 0x00400000 with.
6. Flush and back-to-back:
   - Thread 2 beat at N, flush thread 2 at N+1 -> no out_valid at N+2. Thread 1 beat at N+1 -> valid at N+3.
   - Input plus same-thread flush at N -> dropped.
   - Assert reset mid-stream -> outputs 0 immediately.
